sram_banked_wrapper: RTL
========================

// Module: sram_banked_wrapper
// PURPOSE
//   Parametrised single-port SRAM subsystem built from a grid of hard macros:
//   - NUM_BANKS rows stacked in depth, NUM_COLS columns tiled in width.
//   - Per-column write mask.
//   - Pipelined reads with a returned valid strobe.
//   - Hardware clear engine that zeroes the whole array after reset or on request.
//   Sits between a core-side request port and SRAM1RW<2**MACRO_ADDR_W>x<MACRO_DATA_W> macros.
// PARAMETERS
//   ADDR_W          6   word address width; NUM_BANKS = 2**(ADDR_W-MACRO_ADDR_W)
//   DATA_W          32  word width; NUM_COLS = DATA_W/MACRO_DATA_W (must divide exactly)
//   MACRO_ADDR_W    4   macro address width (macro depth 2**MACRO_ADDR_W)
//   MACRO_DATA_W    16  macro data width, also the write-mask granularity
//   CLEAR_ON_RESET  1   1: enter CLEAR after reset; 0: enter IDLE
// PORTS
//   RW0_clk    in   1          single clock; all macros clocked on CE = RW0_clk
//   RW0_rst    in   1          asynchronous, active-high reset
//   RW0_en     in   1          request valid
//   RW0_wmode  in   1          1 = write, 0 = read
//   RW0_addr   in   ADDR_W     word address; MSBs select bank, LSBs macro address
//   RW0_wdata  in   DATA_W     write data
//   RW0_wmask  in   NUM_COLS   bit c enables write of column c (wdata[c*MACRO_DATA_W +: MACRO_DATA_W])
//   RW0_ready  out  1          request accepted when RW0_en & RW0_ready
//   RW0_rdata  out  DATA_W     read data, valid when RW0_rvalid
//   RW0_rvalid out  1          one-cycle strobe per accepted read
//   RW0_clear  in   1          pulse: request full-array zeroing
//   RW0_busy   out  1          high while in DRAIN or CLEAR
// BEHAVIOUR
//   Reset values:
//   - rvalid = 0, rdata = 0, input/bank pipeline registers cleared.
//   - State = CLEAR (busy = 1, ready = 0) if CLEAR_ON_RESET, else IDLE.
//   FSM:
//   - IDLE: ready = 1. RW0_clear -> DRAIN. A request in the same cycle is still accepted.
//   - DRAIN: exactly 3 cycles; in-flight reads complete normally; -> CLEAR.
//   - CLEAR: counter 0..2**MACRO_ADDR_W-1, one address per cycle.
//     - Every macro in every bank is written with zero: CSB = 0, WEB = 0, I = 0.
//     - After the last address -> IDLE.
//   - RW0_clear is ignored outside IDLE.
//   - Async reset mid-DRAIN or mid-CLEAR aborts and restarts from the reset state.
//   - ready = (state == IDLE), combinational from state only; busy = ~ready.
//   Request pipeline (accept edge = end of cycle N):
//   - Addr, wdata, wmask, wmode and en are registered; they drive the macros in cycle N+1.
//   - Selected bank: CSB = 0.
//   - Unselected banks: CSB = 1, WEB = 1, OEB = 1.
//   - Write: WEB[c] = ~wmask[c]; OEB = 1. Writes produce no response. wmask = 0 is a legal no-op.
//   - Read: all columns of the bank are enabled; OEB = 0, WEB = 1. Bank index is pipelined with the request.
//   - Cycle N+2: the macro O of the pipelined bank is muxed into the output register.
//   - Cycle N+3: rdata/rvalid. Fixed read latency 3; one request per cycle, full throughput.
//   Ordering and hazards:
//   - Responses return in request order.
//   - Read-after-write to the same address in the next cycle returns the new data; no forwarding is needed.
//   - A read accepted in the first IDLE cycle after CLEAR returns 0.
//   - rdata holds its last value while rvalid = 0.
// TESTING
//   1. Defaults, CLEAR_ON_RESET=1; deassert reset:
//      busy high for exactly 16 cycles, then ready = 1; reads of all 64 addresses return 0x00000000.
//   2. Write 0x25 = 0xDEADBEEF with wmask = 2'b11; read 0x25:
//      rvalid exactly 3 cycles after accept, rdata = 0xDEADBEEF.
//   3. Write 0x25 = 0x12345678 with wmask = 2'b01; read 0x25 -> 0xDEAD5678.
//   4. Write 0x05 = 0xAAAA5555 and 0x15 = 0x11112222 (same macro address, banks 0 and 1):
//      reads return each value unchanged.
//   5. Back-to-back reads of 0x05, 0x15, 0x25, 0x35 on consecutive cycles:
//      four consecutive rvalid cycles with data in request order.
//   6. Read 0x25 with RW0_clear in the same cycle:
//      - rdata = 0xDEAD5678 at +3; busy for 3 + 16 cycles; later reads return 0.
//      - Assert reset at clear cycle 7: the 16-cycle clear restarts.

Source files
------------

// File: rtl/sram_banked_wrapper.sv
// sram_banked_wrapper
//   Single-port SRAM subsystem built from a NUM_BANKS x NUM_COLS grid of
//   1RW macros. Banks are stacked in depth, and the upper address bits pick
//   the bank. Columns are tiled in width, and each column has its own write
//   mask bit. Reads are pipelined with a fixed latency of 3 cycles. A clear
//   engine zeroes every macro after reset, or when a clear is requested.
//
//   Each macro is modelled inline as a DEPTH x MACRO_DATA_W array with a
//   registered output, which gives the behaviour of the SRAM1RW hard macro:
//   the address and controls are sampled on the rising edge, and O holds
//   between reads.
//
// Ports
//   RW0_clk     single clock for the wrapper and every macro
//   RW0_rst     asynchronous active-high reset
//   RW0_en      request valid (taken when RW0_en & RW0_ready)
//   RW0_wmode   1 = write, 0 = read
//   RW0_addr    word address {bank, macro address}
//   RW0_wdata   write data
//   RW0_wmask   per-column write enable
//   RW0_ready   high only in IDLE
//   RW0_rdata   read data, qualified by RW0_rvalid, held otherwise
//   RW0_rvalid  one-cycle strobe per accepted read
//   RW0_clear   request full-array zeroing (honoured in IDLE only)
//   RW0_busy    high while draining or clearing
//
// DATA_W must be an exact multiple of MACRO_DATA_W.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | accepting requests
// ST_DRAIN | 3 cycles so that in-flight reads finish before the clear
// ST_CLEAR | write zero to one macro address per cycle in all macros
module sram_banked_wrapper #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter int MACRO_ADDR_W   = 4,
  parameter int MACRO_DATA_W   = 16,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int BANK_W    = ADDR_W - MACRO_ADDR_W,
  localparam int NUM_BANKS = 2 ** BANK_W,
  localparam int NUM_COLS  = DATA_W / MACRO_DATA_W,
  localparam int DEPTH     = 2 ** MACRO_ADDR_W
) (
  input  logic                RW0_clk,
  input  logic                RW0_rst,
  input  logic                RW0_en,
  input  logic                RW0_wmode,
  input  logic [ADDR_W-1:0]   RW0_addr,
  input  logic [DATA_W-1:0]   RW0_wdata,
  input  logic [NUM_COLS-1:0] RW0_wmask,
  output logic                RW0_ready,
  output logic [DATA_W-1:0]   RW0_rdata,
  output logic                RW0_rvalid,
  input  logic                RW0_clear,
  output logic                RW0_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  localparam logic [MACRO_ADDR_W-1:0] CLR_LAST = MACRO_ADDR_W'(DEPTH - 1);
  localparam logic [MACRO_ADDR_W-1:0] CLR_STEP = MACRO_ADDR_W'(1);

  state_t                  state, state_nxt;
  logic [1:0]              drain_cnt;
  logic [MACRO_ADDR_W-1:0] clr_cnt;

  // Request and read pipeline
  logic                accept;
  logic                en_q;
  logic                wmode_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NUM_COLS-1:0] wmask_q;
  logic                rd_p;
  logic [BANK_W-1:0]   bank_p;

  // Macro-side signals
  logic                                clearing;
  logic [MACRO_ADDR_W-1:0]             mac_a;
  logic [DATA_W-1:0]                   mac_i;
  logic [NUM_BANKS-1:0][NUM_COLS-1:0]  mac_csb;
  logic [NUM_BANKS-1:0][NUM_COLS-1:0]  mac_web;
  logic [NUM_BANKS-1:0][NUM_COLS-1:0]  mac_oeb;
  logic [NUM_BANKS-1:0][DATA_W-1:0]    mac_o;

  // The drain timer counts down from 2 and the clear address counts up.
  // Both are reloaded whenever their own state is not active.
  always_ff @(posedge RW0_clk or posedge RW0_rst) begin
    if (RW0_rst) begin
      state     <= RST_STATE;
      drain_cnt <= 2'd2;
      clr_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt - 2'd1 : 2'd2;
      clr_cnt   <= (state == ST_CLEAR) ? clr_cnt + CLR_STEP : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (RW0_clear)             state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 2'd0)     state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_cnt == CLR_LAST)   state_nxt = ST_IDLE;
      default:                             state_nxt = RST_STATE;
    endcase
  end

  assign RW0_ready = (state == ST_IDLE);
  assign RW0_busy  = ~RW0_ready;
  assign accept    = RW0_en & RW0_ready;

  always_ff @(posedge RW0_clk or posedge RW0_rst) begin
    if (RW0_rst) begin
      en_q       <= 1'b0;
      wmode_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rd_p       <= 1'b0;
      bank_p     <= '0;
      RW0_rvalid <= 1'b0;
      RW0_rdata  <= '0;
    end else begin
      en_q <= accept;
      if (accept) begin
        wmode_q <= RW0_wmode;
        addr_q  <= RW0_addr;
        wdata_q <= RW0_wdata;
        wmask_q <= RW0_wmask;
      end
      // The bank index travels with the read so that, one cycle later, it
      // can select the correct macro output.
      rd_p       <= en_q & ~wmode_q;
      bank_p     <= addr_q[ADDR_W-1:MACRO_ADDR_W];
      RW0_rvalid <= rd_p;
      if (rd_p) RW0_rdata <= mac_o[bank_p];
    end
  end

  // Address and data are shared by all macros; only the chip selects and
  // the enables differ between banks and columns.
  always_comb begin
    clearing = (state == ST_CLEAR);
    mac_a    = clearing ? clr_cnt : addr_q[MACRO_ADDR_W-1:0];
    mac_i    = clearing ? '0 : wdata_q;
    mac_csb  = '1;
    mac_web  = '1;
    mac_oeb  = '1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (clearing) begin
          mac_csb[b][c] = 1'b0;
          mac_web[b][c] = 1'b0;
        end else if (en_q && (addr_q[ADDR_W-1:MACRO_ADDR_W] == BANK_W'(b))) begin
          mac_csb[b][c] = 1'b0;
          mac_web[b][c] = wmode_q ? ~wmask_q[c] : 1'b1;
          mac_oeb[b][c] = wmode_q;
        end
      end
    end
  end

  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
      logic [MACRO_DATA_W-1:0] mem [DEPTH];
      logic [MACRO_DATA_W-1:0] o_q;

      always_ff @(posedge RW0_clk) begin
        if (!mac_csb[gb][gc]) begin
          if (!mac_web[gb][gc])
            mem[mac_a] <= mac_i[gc*MACRO_DATA_W +: MACRO_DATA_W];
          else if (!mac_oeb[gb][gc])
            o_q <= mem[mac_a];
        end
      end

      assign mac_o[gb][gc*MACRO_DATA_W +: MACRO_DATA_W] = o_q;
    end
  end

endmodule
